// File: rtl/alu_acc_display.sv
`default_nettype none
// ============================================================================
// Module   : alu_acc_display
// Purpose  : Accumulator ALU with flags, iterative 1-bit/cycle shifter and a
//            time-multiplexed multi-digit 7-segment scanner.
// Options  : SEG_BLANK_EN - leading-zero blanking on digits above digit 0.
// Revision : 1.0
// ============================================================================
module alu_acc_display #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 27000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  operand,
  output logic [WIDTH-1:0]  acc,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              flag_neg,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_en
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNTW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDXW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DISPW = DIGITS * 4;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             shr_q, shr_d;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [SHW-1:0]   shamt;
  logic             accept;

  logic [CNTW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0] dig_en_q, dig_en_d;
  logic [6:0]        seg_q, seg_d;
  logic [DISPW-1:0]  disp;
  logic [DISPW-1:0]  disp_sh;
  logic [3:0]        nib;
  logic              blank;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  assign op_ready = (state_q == ST_IDLE);
  assign accept   = op_valid && op_ready;
  assign shamt    = operand[SHW-1:0];

  // ALU / shifter next-state logic
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    shr_d    = shr_q;
    add_sum  = {1'b0, acc_q} + {1'b0, operand};
    sub_diff = {1'b0, acc_q} - {1'b0, operand};
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_LOAD: acc_d = operand;
            OP_ADD: begin
              acc_d   = add_sum[WIDTH-1:0];
              carry_d = add_sum[WIDTH];
            end
            OP_SUB: begin
              acc_d   = sub_diff[WIDTH-1:0];
              carry_d = sub_diff[WIDTH];
            end
            OP_AND: begin
              acc_d   = acc_q & operand;
              carry_d = 1'b0;
            end
            OP_OR: begin
              acc_d   = acc_q | operand;
              carry_d = 1'b0;
            end
            OP_XOR: begin
              acc_d   = acc_q ^ operand;
              carry_d = 1'b0;
            end
            OP_SHL, OP_SHR: begin
              // A zero-length shift completes immediately and only clears carry
              if (shamt == '0) begin
                carry_d = 1'b0;
              end else begin
                cnt_d   = shamt;
                shr_d   = (op == OP_SHR);
                state_d = ST_SHIFT;
              end
            end
            default: acc_d = acc_q;
          endcase
        end
      end
      ST_SHIFT: begin
        if (shr_q) begin
          carry_d = acc_q[0];
          acc_d   = {1'b0, acc_q[WIDTH-1:1]};
        end else begin
          carry_d = acc_q[WIDTH-1];
          acc_d   = {acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      shr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      shr_q   <= shr_d;
    end
  end

  assign acc        = acc_q;
  assign flag_zero  = (acc_q == '0);
  assign flag_neg   = acc_q[WIDTH-1];
  assign flag_carry = carry_q;

  // Display image is taken from the next accumulator so seg always matches acc
  generate
    if (DISPW > WIDTH) begin : g_pad
      assign disp = {{(DISPW-WIDTH){1'b0}}, acc_d};
    end else begin : g_trunc
      assign disp = acc_d[DISPW-1:0];
    end
  endgenerate

  always_comb begin
    scan_cnt_d = scan_cnt_q + CNTW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == CNTW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
    end
    dig_en_d = DIGITS'(1) << idx_d;
    disp_sh  = disp >> {idx_d, 2'b00};
    nib      = disp_sh[3:0];
    blank    = 1'b0;
`ifdef SEG_BLANK_EN
    blank    = (idx_d != '0) && (disp_sh == '0);
`else
    blank    = 1'b0;
`endif
    seg_d    = blank ? 7'h00 : hex_glyph(nib);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      dig_en_q   <= DIGITS'(1);
      seg_q      <= 7'h3F;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      dig_en_q   <= dig_en_d;
      seg_q      <= seg_d;
    end
  end

  assign dig_en = dig_en_q;
  assign seg    = seg_q;

endmodule
`default_nettype wire
